intc: RTL
=========

Name: intc

Overview:
- Interrupt controller that feeds the single-cycle CPU control unit's interrupt inputs.
- Latches external interrupt request edges into a pending register and maintains the in-service register.
- Presents the highest-priority pending and active requests as one-hot vectors min_bit_s and min_bit_a.
- Consumes the control unit's s_calli (interrupt accepted) and s_reti (interrupt returned) to move requests pending -> in-service -> idle.
- Priority rule: lower bit index wins, i.e. the numerically smaller one-hot value. Bit 0 is reserved for the ALU overflow exception, which the control unit raises internally.

Parameters:
- N, 8, number of interrupt bits (width of every vector port).
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer for each irq line (minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- irq  input  N  asynchronous request lines, rising-edge triggered; irq[0] is ignored.
- mask  input  N  per-bit enable; 1 = may be presented on min_bit_s.
- s_calli  input  N  one-hot accept from the control unit; all-zero = none.
- s_reti  input  N  one-hot return from the control unit; all-zero = none.
- clr_lost  input  1  clears the lost register.
- min_bit_s  output  N  one-hot lowest set bit of (pending & mask); 0 if none.
- min_bit_a  output  N  one-hot lowest set bit of in_service; 0 if none.
- lost  output  N  sticky flag per bit: an edge arrived while that bit was already pending.

Behaviour:
- Reset, synchronous, active-high; on a clock edge with reset=1:
  - synchronizer stages, previous-sample registers, pending, in_service and lost all go to 0.
  - min_bit_s = 0 and min_bit_a = 0 from that edge on.
  - Reset mid-operation discards all pending and in-service state. No partial state survives.
- Synchronizer and edge detection:
  - Each irq[i], for i >= 1, passes through SYNC_STAGES flops, then one previous-sample flop.
  - edge[i] = sync_out[i] & ~prev[i] (combinational).
  - Latency: irq[i] rising before edge E0 -> pending[i] set at edge E0+SYNC_STAGES. With the default, min_bit_s is visible after the 3rd rising edge counting E0.
  - Pulses shorter than one clock period may be missed; this is the accepted limit.
- pending[i], i >= 1, next-state priority:
  - edge[i] -> 1. A new edge wins over a same-cycle s_calli[i].
  - else s_calli[i] -> 0.
  - else hold.
  - pending[0] is constantly 0.
- lost[i]:
  - set when edge[i] & pending[i] & ~s_calli[i].
  - cleared by clr_lost. Set wins if both occur in the same cycle.
- in_service[i], all i including 0, next-state priority:
  - s_calli[i] -> 1, allowing nesting: multiple bits may be in service.
  - else s_reti[i] -> 0.
  - else hold.
  - Same-cycle s_calli[i] and s_reti[i] -> 1.
  - s_reti on a bit not in service has no effect.
  - s_calli on a bit that is not pending (e.g. bit 0 overflow) still sets in_service.
- Masking:
  - mask gates only min_bit_s; a masked pending bit stays pending.
  - Unmasking later presents it with no re-trigger.
- Output logic:
  - min_bit_s and min_bit_a are combinational from registers only; there is no combinational path from s_calli or s_reti to the outputs.
  - Lowest-set-bit isolation is x & (~x + 1), width N, wrap ignored.
- Ack handshake:
  - The control unit holds s_calli while min_bit_s outranks min_bit_a.
  - The accepted bit leaves pending and enters in_service on the same edge.
  - The next cycle therefore shows the new min_bit_a, which stops further acceptance.
- Non-one-hot s_calli or s_reti: each set bit is applied independently; no error raised.

Decomposition:
- Shared package/header holds:
  - constant INT_OVERFLOW_BIT = 0.
  - default N = 8.
  - the lowest-set-bit function, which the control unit priority compare reuses.
- One sub-module, intc_sync_edge: the N-wide synchronizer plus previous-sample flops plus edge output, parameterised by N and SYNC_STAGES.
- Pending, in-service, lost registers and output logic live in intc.

Test Plan:
1. reset=1 for 2 cycles with irq=8'hFF, mask=8'hFF -> pending, in_service, lost = 0; min_bit_s = min_bit_a = 8'h00.
2. Single edge: mask=8'hFF, irq[3] rises before edge E0 -> min_bit_s=8'h08 after E0+2. Then s_calli=8'h08 for one cycle -> next cycle min_bit_s=8'h00, min_bit_a=8'h08. Then s_reti=8'h08 -> min_bit_a=8'h00.
3. Priority and nesting:
   - irq[5] rises and is accepted: min_bit_a=8'h20.
   - Then irq[2] rises: min_bit_s=8'h04, which outranks. s_calli=8'h04 -> min_bit_a=8'h04.
   - s_reti=8'h04 -> min_bit_a=8'h20.
4. Masking and lost: mask=8'h00, irq[1] pulsed twice -> min_bit_s=8'h00, lost=8'h02. Set mask=8'h02 -> min_bit_s=8'h02. Pulse clr_lost -> lost=8'h00.
5. Overflow path: s_calli=8'h01 with no request -> min_bit_a=8'h01; s_reti=8'h01 -> min_bit_a=8'h00. irq[0] toggling never changes pending.
6. Simultaneous events:
   - edge[4] in the same cycle as s_calli=8'h10 (bit 4 pending) -> pending[4] stays 1 and in_service[4]=1.
   - s_reti=8'h40 with in_service=8'h00 -> no change.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared interrupt-controller constants and the lowest-set-bit helper,
// also used by the control unit's priority compare.
package intc_pkg;

  localparam int unsigned INT_OVERFLOW_BIT = 0;
  localparam int unsigned INTC_DEFAULT_N   = 8;
  localparam int unsigned INTC_MAX_N       = 32;

  // Isolates the lowest set bit; callers zero-extend narrower vectors to INTC_MAX_N.
  function automatic logic [INTC_MAX_N-1:0] lowest_set_bit(input logic [INTC_MAX_N-1:0] x);
    return x & (~x + INTC_MAX_N'(1));
  endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// N-wide irq synchronizer followed by a previous-sample flop per line;
// irq_edge flags a synchronized rising edge for one cycle.
module intc_sync_edge #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq,
  output logic [N-1:0] irq_edge
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intc.sv
// Interrupt controller: latches irq edges into pending, tracks in-service
// requests and presents the highest-priority (lowest index) of each one-hot.
module intc
  import intc_pkg::*;
#(
  parameter int unsigned N           = INTC_DEFAULT_N,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] s_calli,
  input  logic [N-1:0] s_reti,
  input  logic         clr_lost,
  output logic [N-1:0] min_bit_s,
  output logic [N-1:0] min_bit_a,
  output logic [N-1:0] lost
);

  // The overflow bit is raised inside the control unit, never from irq.
  localparam logic [N-1:0] REQ_BITS = ~(N'(1) << INT_OVERFLOW_BIT);

  logic [N-1:0] irq_edge;
  logic [N-1:0] req_edge;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;

  intc_sync_edge #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .irq_edge (irq_edge)
  );

  assign req_edge = irq_edge & REQ_BITS;

  // A new edge beats a same-cycle accept; a same-cycle call beats a return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      in_service <= '0;
      lost       <= '0;
    end else begin
      pending    <= ((pending & ~s_calli) | req_edge) & REQ_BITS;
      in_service <= (in_service & ~s_reti) | s_calli;
      lost       <= (clr_lost ? '0 : lost) | (req_edge & pending & ~s_calli);
    end
  end

  assign min_bit_s = N'(lowest_set_bit(INTC_MAX_N'(pending & mask)));
  assign min_bit_a = N'(lowest_set_bit(INTC_MAX_N'(in_service)));

endmodule
